// File: rtl/scan_code_fifo_if.sv
// rtl/scan_code_fifo_if.sv - push/pop/status bundle between PS/2 receiver, scan-code FIFO and consumer
interface scan_code_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) ();
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_ready;
    logic              clr_ovf;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output wr_en, wr_data, rd_ready, clr_ovf,
        input  rd_valid, rd_data, count, full, empty, overflow
    );

    modport slave (
        input  wr_en, wr_data, rd_ready, clr_ovf,
        output rd_valid, rd_data, count, full, empty, overflow
    );
endinterface

// File: rtl/scan_code_fifo.sv
// rtl/scan_code_fifo.sv - scan-code FIFO with show-ahead read, sticky overflow and drop/overwrite policy
module scan_code_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int OVERWRITE = 0
) (
    input  logic           clk,
    input  logic           rst,
    scan_code_fifo_if.slave bus
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf;

    logic full_i;
    logic empty_i;
    logic pop;
    logic ovf_evt;
    logic evict;
    logic push_ok;

    // Status comes only from the registered count, never from wr_en.
    always_comb begin
        full_i  = (cnt == FULL_CNT);
        empty_i = (cnt == '0);
        pop     = !empty_i & bus.rd_ready;
        ovf_evt = bus.wr_en & full_i & !pop;
        evict   = ovf_evt & (OVERWRITE != 0);
        push_ok = bus.wr_en & (!full_i | pop | evict);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            // An overwrite-full push retires the oldest entry like a pop.
            if (pop | evict) rptr <= rptr + 1'b1;
            if (push_ok & !pop & !evict) cnt <= cnt + 1'b1;
            else if (pop & !push_ok)     cnt <= cnt - 1'b1;
            if (ovf_evt)          ovf <= 1'b1;
            else if (bus.clr_ovf) ovf <= 1'b0;
        end
    end

    assign bus.rd_valid = !empty_i;
    assign bus.rd_data  = empty_i ? '0 : mem[rptr];
    assign bus.count    = cnt;
    assign bus.full     = full_i;
    assign bus.empty    = empty_i;
    assign bus.overflow = ovf;
endmodule

// File: doc/scan_code_fifo.md
Name: scan_code_fifo

Overview:
Parametrised successor to the single-entry enable register that captures received PS/2 scan codes. Buffers up to DEPTH codes between the PS/2 receiver (push on data-valid strobe) and the consumer logic (valid/ready pop). Adds occupancy and full/empty status, a sticky overflow flag, and a selectable drop-new or overwrite-oldest policy when full.

Parameters:
DATA_W, 8, width of each stored code
ADDR_W, 2, pointer width; DEPTH = 2**ADDR_W entries; legal range 1..6
OVERWRITE, 0, 0 = drop incoming code when full; 1 = discard oldest entry and store incoming code

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  push strobe, one code per cycle high
wr_data  in  DATA_W  code to push
rd_ready  in  1  consumer accepts head entry this cycle
clr_ovf  in  1  synchronous clear of overflow flag
rd_valid  out  1  head entry present (= !empty)
rd_data  out  DATA_W  head entry (show-ahead); all zeros when empty
count  out  ADDR_W+1  occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: a push arrived while full with no same-cycle pop

Behaviour:
- Reset (async, immediate): write ptr = 0, read ptr = 0, count = 0, overflow = 0, so empty = 1, full = 0, rd_valid = 0, rd_data = 0. Storage array is not reset. Reset mid-operation discards all contents.
- pop = rd_valid & rd_ready. push_ok = wr_en & (!full | pop | OVERWRITE).
- Push: mem[wptr] <= wr_data; wptr increments modulo DEPTH (natural wrap of ADDR_W bits).
- Pop: rptr increments modulo DEPTH.
- count next = count + push_ok - pop, except in the overwrite-full case below.
- Latency: a code pushed at edge N is visible on rd_data with rd_valid = 1 after edge N (same cycle the status updates). rd_data is combinational from mem[rptr], masked to zero when empty.
- Empty with wr_en and rd_ready both high: no pop because rd_valid = 0. Push stored; count becomes 1.
- Full with wr_en and pop in the same cycle: both proceed; count stays DEPTH; overflow not set.
- Full with wr_en and no pop, OVERWRITE = 0: wr_data dropped; pointers and count unchanged; overflow <= 1.
- Full with wr_en and no pop, OVERWRITE = 1: store at wptr and advance both wptr and rptr; count stays DEPTH; oldest code lost; overflow <= 1.
- Overflow is sticky until clr_ovf. If clr_ovf and a new overflow event occur in the same cycle, the set wins (overflow = 1).
- rd_ready while empty has no effect. No other error conditions.
- Status outputs full, empty, count and rd_valid are all derived from the registered count; no combinational path from wr_en to status.

Test Plan:
- Reset then idle: count = 0, empty = 1, rd_valid = 0, rd_data = 0x00. Assert rst mid-stream with 3 entries: all outputs return to reset values immediately.
- DEPTH = 4, push 0x1C, 0xF0, 0x1C, 0x5A on consecutive cycles with rd_ready = 0: full = 1, count = 4. Then hold rd_ready = 1: pops return 0x1C, 0xF0, 0x1C, 0x5A in order and empty = 1 afterwards.
- OVERWRITE = 0, full with 0x11..0x14, push 0x99 with no pop: overflow = 1, contents unchanged. Drain yields 0x11..0x14. Pulse clr_ovf: overflow = 0.
- OVERWRITE = 1, full with 0x11..0x14, push 0x99: count = 4, overflow = 1. Drain yields 0x12, 0x13, 0x14, 0x99.
- Full with simultaneous push 0x77 and pop: pop returns head, count stays 4, overflow stays 0. Empty with simultaneous wr_en = 1 (0x33) and rd_ready = 1: count = 1, rd_data = 0x33 next cycle.
- Wrap-around: 10 interleaved push/pop pairs with pointers crossing index 3 to 0: data order preserved throughout. Same-cycle clr_ovf and overflow event: overflow = 1.
